exp_batch_master: RTL and testbench

- Host-side initiator for the 32-entry batched exp MMIO accelerator. It is the other end of the accelerator's load / compute / read-back protocol.
- Accepts a stream of 32 operands and pushes them over the accelerator's input handshake. It then waits for results, reads all 32 back by address, and emits them as an ordered output stream.
- Afterwards it re-arms the accelerator with a reset pulse, because the accelerator's results-ready state is sticky.
- Sits between the Chipyard MMIO register front-end / stream source and the accelerator instance.

---
 rtl/exp_batch_pkg.sv | 13 +
 rtl/exp_batch_out_reg.sv | 55 +++++
 rtl/exp_batch_master.sv | 165 ++++++++++++++++
 tb/tb_exp_batch_master.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_batch_pkg.sv
// Shared constants for the batched-exp host initiator: FSM encoding, batch size
// and the default wait-state timeout.
package exp_batch_pkg;

  localparam int BATCH                  = 32;
  localparam int TIMEOUT_CYCLES_DEFAULT = 2048;

  localparam logic [1:0] S_RECYCLE = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

endpackage

// File: rtl/exp_batch_out_reg.sv
// One-entry output holding register with valid/ready and a last flag.
// Data and last stay stable while the consumer stalls.
module exp_batch_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             space_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             last_o
);

  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Room for a new word when empty or when the held word leaves this cycle.
  assign space_o = ~valid_q | ready_i;

  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      last_d  = last_i;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/exp_batch_master.sv
// Host-side initiator for the 32-entry batched exp accelerator: loads a batch,
// waits for results, reads them back in order, then re-arms the accelerator.
module exp_batch_master
  import exp_batch_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BATCH          = exp_batch_pkg::BATCH,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int RECYCLE_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             acc_input_valid,
  input  logic             acc_input_ready,
  output logic [WIDTH-1:0] acc_ax,
  output logic [4:0]       acc_read_addr,
  input  logic             acc_output_valid,
  output logic             acc_output_ready,
  input  logic [WIDTH-1:0] acc_res,
  input  logic             acc_busy,
  output logic             acc_reset,
  output logic             err_timeout,
  input  logic             err_clear,
  output logic             batch_done
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(RECYCLE_CYCLES + 1);

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] cyc_q, cyc_d;
  logic [4:0]    wr_idx_q, wr_idx_d;
  logic [5:0]    rd_idx_q, rd_idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic          clean_q, clean_d;
  logic          err_set;
  logic          recycle_done;
  logic          out_space;
  logic          out_load;
  logic          out_xfer;

  assign acc_ax           = in_data;
  assign acc_input_valid  = in_valid & (state_q == S_LOAD);
  assign in_ready         = acc_input_ready & (state_q == S_LOAD);
  assign acc_output_ready = (state_q == S_WAIT);
  assign acc_read_addr    = rd_idx_q[4:0];
  assign acc_reset        = ~reset | (state_q == S_RECYCLE);
  assign err_timeout      = err_q;

  assign recycle_done = (state_q == S_RECYCLE) && (cyc_q == RW'(RECYCLE_CYCLES - 1));
  // clean_q marks a recycle entered by normal completion rather than an error.
  assign batch_done   = recycle_done & clean_q;

  assign out_load = (state_q == S_DRAIN) && out_space && (rd_idx_q < 6'(BATCH));
  assign out_xfer = out_valid & out_ready;

  exp_batch_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk_i  (clock),
    .rst_ni (reset),
    .load_i (out_load),
    .data_i (acc_res),
    .last_i (rd_idx_q == 6'(BATCH - 1)),
    .ready_i(out_ready),
    .space_o(out_space),
    .valid_o(out_valid),
    .data_o (out_data),
    .last_o (out_last)
  );

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    timer_d  = timer_q;
    clean_d  = clean_q;
    err_set  = 1'b0;
    case (state_q)
      S_RECYCLE: begin
        rd_idx_d = '0;
        timer_d  = '0;
        if (recycle_done) begin
          state_d = S_LOAD;
          clean_d = 1'b0;
        end else begin
          cyc_d = cyc_q + RW'(1);
        end
      end
      S_LOAD: begin
        // A busy accelerator before the first word means it is out of step with us.
        if (acc_busy && (wr_idx_q == 5'd0)) begin
          err_set = 1'b1;
          state_d = S_RECYCLE;
          cyc_d   = '0;
          clean_d = 1'b0;
        end else if (in_valid && in_ready) begin
          if (wr_idx_q == 5'(BATCH - 1)) begin
            wr_idx_d = '0;
            timer_d  = '0;
            state_d  = S_WAIT;
          end else begin
            wr_idx_d = wr_idx_q + 5'd1;
          end
        end
      end
      S_WAIT: begin
        if (acc_output_valid) begin
          rd_idx_d = '0;
          state_d  = S_DRAIN;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_set = 1'b1;
          state_d = S_RECYCLE;
          cyc_d   = '0;
          clean_d = 1'b0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (out_load) rd_idx_d = rd_idx_q + 6'd1;
        if (out_xfer && out_last) begin
          state_d = S_RECYCLE;
          cyc_d   = '0;
          clean_d = 1'b1;
        end
      end
      default: state_d = S_RECYCLE;
    endcase
    // A fresh error outranks a clear in the same cycle.
    if (err_set)        err_d = 1'b1;
    else if (err_clear) err_d = 1'b0;
    else                err_d = err_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RECYCLE;
      cyc_q    <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      clean_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      clean_q  <= clean_d;
    end
  end

endmodule

// File: tb/tb_exp_batch_master.sv
// Directed bench for exp_batch_master with a behavioural accelerator
// (result = ax + 1, 30 cycles per word, sticky results-ready).
module tb_exp_batch_master;

  logic        clock;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        acc_input_valid, acc_input_ready;
  logic [31:0] acc_ax, acc_res;
  logic [4:0]  acc_read_addr;
  logic        acc_output_valid, acc_output_ready;
  logic        acc_busy, acc_reset;
  logic        err_timeout, err_clear, batch_done;

  logic        hang, force_busy;
  logic [31:0] mem [32];
  logic [5:0]  ld_cnt;
  logic        computing, done;
  int          left;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int rst_rise = 0;
  logic rst_prev = 1'b0;
  int rise0;

  exp_batch_master dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .acc_input_valid (acc_input_valid),
    .acc_input_ready (acc_input_ready),
    .acc_ax          (acc_ax),
    .acc_read_addr   (acc_read_addr),
    .acc_output_valid(acc_output_valid),
    .acc_output_ready(acc_output_ready),
    .acc_res         (acc_res),
    .acc_busy        (acc_busy),
    .acc_reset       (acc_reset),
    .err_timeout     (err_timeout),
    .err_clear       (err_clear),
    .batch_done      (batch_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Accelerator model
  assign acc_input_ready  = !computing && !done && (ld_cnt < 6'd32);
  assign acc_busy         = computing | force_busy;
  assign acc_output_valid = done;
  assign acc_res          = mem[acc_read_addr];

  always @(posedge clock) begin
    if (acc_reset) begin
      ld_cnt    <= 6'd0;
      computing <= 1'b0;
      done      <= 1'b0;
      left      <= 0;
    end else if (acc_input_valid && acc_input_ready) begin
      mem[ld_cnt[4:0]] <= acc_ax + 32'd1;
      ld_cnt           <= ld_cnt + 6'd1;
      if (ld_cnt == 6'd31) begin
        computing <= 1'b1;
        left      <= 32 * 30;
      end
    end else if (computing && !hang) begin
      if (left == 1) begin
        computing <= 1'b0;
        done      <= 1'b1;
      end
      left <= left - 1;
    end
  end

  always @(negedge clock) begin
    if (batch_done === 1'b1) done_cnt <= done_cnt + 1;
    if (acc_reset === 1'b1 && rst_prev === 1'b0) rst_rise <= rst_rise + 1;
    rst_prev <= acc_reset;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic feed_batch(input logic [31:0] base, input bit gaps);
    int   i   = 0;
    int   cyc = 0;
    logic hs;
    while (i < 32 && cyc < 500) begin
      in_valid = !(gaps && (cyc % 3 == 1));
      in_data  = base + 32'(i);
      hs       = in_valid && in_ready;
      tick;
      cyc++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    check_eq("fed", 32'(i), 32'd32);
  endtask

  task automatic drain_batch(input logic [31:0] base, input int stall_at, input int abort_at);
    int          n     = 0;
    int          stall = 0;
    int          cyc   = 0;
    logic [31:0] held  = '0;
    out_ready = 1'b1;
    while (n < 32 && cyc < 3000) begin
      if (abort_at >= 0 && n == abort_at) begin
        reset = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_acc_reset", 32'(acc_reset), 32'd1);
        check_eq("rst_read_addr", 32'(acc_read_addr), 32'd0);
        return;
      end
      if (stall_at >= 0 && n == stall_at && stall < 10) begin
        if (stall == 0) held = out_data;
        else check_eq("stall_hold", out_data, held);
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        check_eq("out_data", out_data, base + 32'(n) + 32'd1);
        check_eq("out_last", 32'(out_last), 32'(n == 31));
        n++;
      end
      tick;
      cyc++;
    end
    check_eq("drained", 32'(n), 32'd32);
    check_eq("no_extra", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    err_clear  = 1'b0;
    hang       = 1'b0;
    force_busy = 1'b0;
    #2 reset = 1'b0;
    repeat (2) tick;

    check_eq("rst_acc_reset", 32'(acc_reset), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_batch_done", 32'(batch_done), 32'd0);
    check_eq("rst_err", 32'(err_timeout), 32'd0);
    check_eq("rst_out_data", out_data, 32'd0);
    check_eq("rst_read_addr", 32'(acc_read_addr), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);

    reset = 1'b1;
    tick;
    check_eq("recycle1_acc_reset", 32'(acc_reset), 32'd1);
    check_eq("recycle1_in_ready", 32'(in_ready), 32'd0);
    tick;
    check_eq("load_acc_reset", 32'(acc_reset), 32'd0);
    check_eq("load_in_ready", 32'(in_ready), 32'd1);

    // Batch 0..31
    feed_batch(32'd0, 1'b0);
    drain_batch(32'd0, -1, -1);
    repeat (3) tick;
    check_eq("done_cnt1", 32'(done_cnt), 32'd1);

    // Input gaps and a 10-cycle output stall
    feed_batch(32'd500, 1'b1);
    drain_batch(32'd500, 12, -1);
    repeat (3) tick;
    check_eq("done_cnt2", 32'(done_cnt), 32'd2);

    // Back-to-back batches
    rise0 = rst_rise;
    feed_batch(32'd100, 1'b0);
    drain_batch(32'd100, -1, -1);
    feed_batch(32'd200, 1'b0);
    check_eq("recycle_between", 32'(rst_rise - rise0), 32'd1);
    drain_batch(32'd200, -1, -1);
    repeat (3) tick;
    check_eq("done_cnt4", 32'(done_cnt), 32'd4);

    // Timeout: accelerator never finishes
    hang = 1'b1;
    feed_batch(32'h40, 1'b0);
    repeat (2047) tick;
    check_eq("to_err_early", 32'(err_timeout), 32'd0);
    tick;
    check_eq("to_err_set", 32'(err_timeout), 32'd1);
    check_eq("to_acc_reset", 32'(acc_reset), 32'd1);
    check_eq("to_out_valid", 32'(out_valid), 32'd0);
    repeat (2) tick;
    check_eq("to_reload", 32'(in_ready), 32'd1);
    check_eq("to_no_done", 32'(done_cnt), 32'd4);

    // Clear coincident with a new timeout: timeout wins
    feed_batch(32'h80, 1'b0);
    repeat (2047) tick;
    err_clear = 1'b1;
    tick;
    check_eq("clr_vs_to", 32'(err_timeout), 32'd1);
    check_eq("clr_vs_to_recycle", 32'(acc_reset), 32'd1);
    tick;
    err_clear = 1'b0;
    check_eq("err_cleared", 32'(err_timeout), 32'd0);
    tick;
    hang = 1'b0;

    // Busy accelerator at the start of a load
    force_busy = 1'b1;
    tick;
    force_busy = 1'b0;
    check_eq("desync_err", 32'(err_timeout), 32'd1);
    check_eq("desync_recycle", 32'(acc_reset), 32'd1);
    repeat (2) tick;
    check_eq("desync_reload", 32'(in_ready), 32'd1);
    err_clear = 1'b1;
    tick;
    err_clear = 1'b0;
    check_eq("desync_clear", 32'(err_timeout), 32'd0);

    // Reset in the middle of a drain, then a fresh batch
    feed_batch(32'h300, 1'b0);
    drain_batch(32'h300, -1, 17);
    tick;
    reset = 1'b1;
    feed_batch(32'h400, 1'b0);
    drain_batch(32'h400, -1, -1);
    repeat (3) tick;
    check_eq("done_cnt5", 32'(done_cnt), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
